gpio_sel_config: RTL and testbench

- Wishbone-slave configuration and sequencing block that owns the 4-bit per-pin design-select lines driving the GPIO output mux.
- Holds a shadow and an active copy of all 38 selects.
- On any select change, it forces the affected pins to high-impedance (oeb=1) for a guard window, then applies the new select. This prevents contention and glitches during hand-over between designs.
- Sits between the Wishbone bus and the GPIO mux. Its force_oeb mask is ORed into the muxed oeb downstream.

---
 rtl/gpio_ctrl_pkg.sv | 23 ++
 rtl/gpio_sel_guard.sv | 72 +++++++
 rtl/gpio_sel_config.sv | 149 ++++++++++++++
 tb/tb_gpio_sel_config.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants, register offsets and sequencer state type for the GPIO design-select block.
package gpio_ctrl_pkg;

    localparam int NUM_PINS      = 38;
    localparam int PINS_PER_WORD = 8;
    localparam int SEL_W         = 4;
    localparam int NUM_SEL_WORDS = 5;

    localparam logic [4:0] SEL0_OFF   = 5'h00;
    localparam logic [4:0] SEL1_OFF   = 5'h04;
    localparam logic [4:0] SEL2_OFF   = 5'h08;
    localparam logic [4:0] SEL3_OFF   = 5'h0C;
    localparam logic [4:0] SEL4_OFF   = 5'h10;
    localparam logic [4:0] STATUS_OFF = 5'h14;
    localparam logic [4:0] LOCK_OFF   = 5'h18;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        APPLY
    } guard_state_t;

endpackage

// File: rtl/gpio_sel_guard.sv
// Hand-over sequencer: tristates the changed pins for a guard window, then
// pulses apply so the new selects take effect one cycle before oeb is released.
module gpio_sel_guard
    import gpio_ctrl_pkg::*;
#(
    parameter int GUARD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_PINS-1:0] changed_mask,
    output logic                apply,
    output logic [NUM_PINS-1:0] force_oeb,
    output logic                busy
);

    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    guard_state_t       state, state_next;
    logic [CW-1:0]      count, count_next;
    logic [NUM_PINS-1:0] oeb_q, oeb_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            oeb_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            oeb_q <= oeb_next;
        end
    end

    // A start with nothing changed leaves the sequencer idle, so no oeb pulse appears.
    always_comb begin
        state_next = state;
        count_next = count;
        oeb_next   = oeb_q;
        apply      = 1'b0;
        case (state)
            IDLE: begin
                oeb_next = '0;
                if (start && (|changed_mask)) begin
                    state_next = GUARD;
                    oeb_next   = changed_mask;
                    count_next = CW'(GUARD_CYCLES - 1);
                end
            end
            GUARD: begin
                if (count == '0) begin
                    apply      = 1'b1;
                    state_next = APPLY;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            APPLY: begin
                state_next = IDLE;
                oeb_next   = '0;
            end
            default: begin
                state_next = IDLE;
                oeb_next   = '0;
            end
        endcase
    end

    assign force_oeb = oeb_q;
    assign busy      = (state != IDLE);

endmodule

// File: rtl/gpio_sel_config.sv
// Wishbone register block holding shadow/active per-pin design selects for the GPIO mux.
// Optional write-once LOCK register at 0x18 when GPIO_SEL_LOCK_EN is defined.
module gpio_sel_config
    import gpio_ctrl_pkg::*;
#(
    parameter int          NUM_DESIGNS  = 13,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic          wb_ack_o,
    output logic [31:0]   wb_dat_o,
    output logic [31:0]   pin_0to7_sel,
    output logic [31:0]   pin_8to15_sel,
    output logic [31:0]   pin_16to23_sel,
    output logic [31:0]   pin_24to31_sel,
    output logic [23:0]   pin_32to37_sel,
    output logic [37:0]   force_oeb,
    output logic          busy
);

    localparam int LAST_WORD_PINS = NUM_PINS - (NUM_SEL_WORDS - 1) * PINS_PER_WORD;

    logic [NUM_SEL_WORDS-1:0][31:0] shadow, active, new_shadow;
    logic [NUM_PINS-1:0]            changed_mask;
    logic [NUM_SEL_WORDS-1:0]       pending;
    logic [2:0]                     word;
    logic [4:0]                     byte_off;
    logic [31:0]                    rdata;
    logic hit, req, is_sel, accept, sel_write, sel_wr, lock_reject, status_wr;
    logic bad_nibble, apply, err, locked;
    logic unused_bits;

    assign word      = wb_adr_i[4:2];
    assign byte_off  = {word, 2'b00};
    assign hit       = (wb_adr_i[31:5] == BASE_ADDR[31:5]);
    assign req       = wb_cyc_i && wb_stb_i && !wb_ack_o && hit;
    assign is_sel    = (word <= 3'(NUM_SEL_WORDS - 1));

    // Select writes stall during a hand-over; a locked block still acks them at once.
    assign accept      = req && (!wb_we_i || !is_sel || !busy || locked);
    assign sel_write   = accept && wb_we_i && is_sel;
    assign sel_wr      = sel_write && !locked;
    assign lock_reject = sel_write && locked;
    assign status_wr   = accept && wb_we_i && (byte_off == STATUS_OFF);

    // Merge the enabled, legal nibbles into a candidate shadow word.
    always_comb begin
        new_shadow = shadow;
        bad_nibble = 1'b0;
        if (is_sel) begin
            for (int k = 0; k < PINS_PER_WORD; k++) begin
                if (!((word == 3'(NUM_SEL_WORDS - 1)) && (k >= LAST_WORD_PINS)) && wb_sel_i[k/2]) begin
                    if (int'(wb_dat_i[k*SEL_W +: SEL_W]) < NUM_DESIGNS)
                        new_shadow[word][k*SEL_W +: SEL_W] = wb_dat_i[k*SEL_W +: SEL_W];
                    else
                        bad_nibble = 1'b1;
                end
            end
        end
    end

    always_comb begin
        changed_mask = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            changed_mask[p] = (new_shadow[p/PINS_PER_WORD][(p%PINS_PER_WORD)*SEL_W +: SEL_W]
                               != active[p/PINS_PER_WORD][(p%PINS_PER_WORD)*SEL_W +: SEL_W]);
        end
        for (int w = 0; w < NUM_SEL_WORDS; w++) begin
            pending[w] = (shadow[w] != active[w]);
        end
    end

    always_comb begin
        rdata = '0;
        if (is_sel)
            rdata = shadow[word];
        else if (byte_off == STATUS_OFF)
            rdata = {19'b0, pending, 6'b0, err, busy};
`ifdef GPIO_SEL_LOCK_EN
        else if (byte_off == LOCK_OFF)
            rdata = {31'b0, locked};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            active   <= '0;
            err      <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= (accept && !wb_we_i) ? rdata : '0;
            if (sel_wr)
                shadow <= new_shadow;
            if (apply)
                active <= shadow;
            if ((sel_wr && bad_nibble) || lock_reject)
                err <= 1'b1;
            else if (status_wr && wb_sel_i[0] && wb_dat_i[1])
                err <= 1'b0;
        end
    end

`ifdef GPIO_SEL_LOCK_EN
    logic lock_q;

    // Lock is write-once: only reset can release it.
    always_ff @(posedge clk) begin
        if (rst)
            lock_q <= 1'b0;
        else if (accept && wb_we_i && (byte_off == LOCK_OFF) && wb_sel_i[0] && wb_dat_i[0])
            lock_q <= 1'b1;
    end
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    gpio_sel_guard #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guard (
        .clk          (clk),
        .rst          (rst),
        .start        (sel_wr),
        .changed_mask (changed_mask),
        .apply        (apply),
        .force_oeb    (force_oeb),
        .busy         (busy)
    );

    assign pin_0to7_sel   = active[0];
    assign pin_8to15_sel  = active[1];
    assign pin_16to23_sel = active[2];
    assign pin_24to31_sel = active[3];
    assign pin_32to37_sel = active[4][23:0];

    assign unused_bits = ^{wb_adr_i[1:0], active[4][31:24]};

endmodule

// File: tb/tb_gpio_sel_config.sv
// Self-checking bench for gpio_sel_config: register table with a read scoreboard,
// plus hand-written guard-timing, stall, reset-abort and (optional) lock sequences.
module tb_gpio_sel_config;

    localparam int          G    = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          NV   = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_ack;
    logic [31:0] wb_rdat;
    logic [31:0] p0, p1, p2, p3;
    logic [23:0] p4;
    logic [37:0] force_oeb;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic        we;
        logic [2:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[NV];

    gpio_sel_config #(
        .NUM_DESIGNS  (13),
        .GUARD_CYCLES (G),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_cyc_i       (wb_cyc),
        .wb_stb_i       (wb_stb),
        .wb_we_i        (wb_we),
        .wb_adr_i       (wb_adr),
        .wb_dat_i       (wb_dat),
        .wb_sel_i       (wb_sel),
        .wb_ack_o       (wb_ack),
        .wb_dat_o       (wb_rdat),
        .pin_0to7_sel   (p0),
        .pin_8to15_sel  (p1),
        .pin_16to23_sel (p2),
        .pin_24to31_sel (p3),
        .pin_32to37_sel (p4),
        .force_oeb      (force_oeb),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(logic we, logic [2:0] off, logic [31:0] dat, logic [3:0] sel, logic [31:0] exp);
        vec_t v;
        v.we = we; v.off = off; v.dat = dat; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] grpSel(int g);
        case (g)
            0: return p0;
            1: return p1;
            2: return p2;
            3: return p3;
            4: return {8'h00, p4};
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One Wishbone transfer; read expectations go through the scoreboard queue.
    task automatic applyStimulus(input logic we, input logic [2:0] off, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [31:0] exp, output int lat);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = BASE + {27'b0, off, 2'b00};
        wb_dat = dat; wb_sel = sel;
        if (!we) expQ.push_back(exp);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack && lat < 50);
        if (!wb_ack) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: no ack after %0d cycles, required ack", lat);
            if (!we && expQ.size() > 0) void'(expQ.pop_front());
        end else if (!we) begin
            logic [31:0] want;
            want = expQ.pop_front();
            checkOutput($sformatf("read_off%0d", off), {32'h0, wb_rdat}, {32'h0, want});
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Called on the negedge right after the write ack; walks the guard window.
    task automatic watchGuard(input logic [37:0] mask, input int grp, input logic [31:0] oldv, input logic [31:0] newv);
        for (int k = 1; k <= G + 2; k++) begin
            checkOutput($sformatf("force_oeb_c%0d", k), {26'h0, force_oeb}, (k <= G + 1) ? {26'h0, mask} : 64'h0);
            checkOutput($sformatf("busy_c%0d", k), {63'h0, busy}, (k <= G + 1) ? 64'h1 : 64'h0);
            checkOutput($sformatf("pins_c%0d", k), {32'h0, grpSel(grp)}, (k >= G + 1) ? {32'h0, newv} : {32'h0, oldv});
            if (k < G + 2) @(negedge clk);
        end
    endtask

    initial begin
        int lat;

        tbl[0]  = mk(1'b0, 3'd0, 32'h0,         4'hF, 32'h0);
        tbl[1]  = mk(1'b0, 3'd1, 32'h0,         4'hF, 32'h0);
        tbl[2]  = mk(1'b0, 3'd2, 32'h0,         4'hF, 32'h0);
        tbl[3]  = mk(1'b0, 3'd3, 32'h0,         4'hF, 32'h0);
        tbl[4]  = mk(1'b0, 3'd4, 32'h0,         4'hF, 32'h0);
        tbl[5]  = mk(1'b0, 3'd5, 32'h0,         4'hF, 32'h0);
        tbl[6]  = mk(1'b1, 3'd0, 32'h0000_000D, 4'hF, 32'h0);
        tbl[7]  = mk(1'b0, 3'd0, 32'h0,         4'hF, 32'h0);
        tbl[8]  = mk(1'b0, 3'd5, 32'h0,         4'hF, 32'h2);
        tbl[9]  = mk(1'b1, 3'd5, 32'h2,         4'h1, 32'h0);
        tbl[10] = mk(1'b0, 3'd5, 32'h0,         4'hF, 32'h0);
        tbl[11] = mk(1'b1, 3'd3, 32'hFFFF_FFFF, 4'h1, 32'h0);
        tbl[12] = mk(1'b0, 3'd3, 32'h0,         4'hF, 32'h0);
        tbl[13] = mk(1'b0, 3'd5, 32'h0,         4'hF, 32'h2);
        tbl[14] = mk(1'b1, 3'd5, 32'h2,         4'h1, 32'h0);
        tbl[15] = mk(1'b1, 3'd3, 32'h0000_0055, 4'h1, 32'h0);
        tbl[16] = mk(1'b0, 3'd3, 32'h0,         4'hF, 32'h0000_0055);
        tbl[17] = mk(1'b1, 3'd4, 32'h7712_3456, 4'hF, 32'h0);
        tbl[18] = mk(1'b0, 3'd4, 32'h0,         4'hF, 32'h0012_3456);
        tbl[19] = mk(1'b0, 3'd5, 32'h0,         4'hF, 32'h0);
        tbl[20] = mk(1'b1, 3'd2, 32'hC0A0_5001, 4'hA, 32'h0);
        tbl[21] = mk(1'b0, 3'd2, 32'h0,         4'hF, 32'hC000_5000);
        tbl[22] = mk(1'b1, 3'd7, 32'h1234_5678, 4'hF, 32'h0);
        tbl[23] = mk(1'b0, 3'd7, 32'h0,         4'hF, 32'h0);
        tbl[24] = mk(1'b0, 3'd6, 32'h0,         4'hF, 32'h0);
        tbl[25] = mk(1'b0, 3'd0, 32'h0,         4'hF, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("reset_ack", {63'h0, wb_ack}, 64'h0);
        checkOutput("reset_rdat", {32'h0, wb_rdat}, 64'h0);
        checkOutput("reset_force_oeb", {26'h0, force_oeb}, 64'h0);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_pins_lo", {p1, p0}, 64'h0);
        checkOutput("reset_pins_hi", {8'h0, p4, p3 | p2}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(tbl[i].we, tbl[i].off, tbl[i].dat, tbl[i].sel, tbl[i].exp, lat);
            checkOutput($sformatf("tbl%0d_latency", i), lat, 64'd1);
            if (tbl[i].we) waitIdle();
        end
        checkOutput("tbl_pins_24to31", {32'h0, p3}, 64'h55);
        checkOutput("tbl_pins_32to37", {40'h0, p4}, 64'h12_3456);
        checkOutput("tbl_pins_16to23", {32'h0, p2}, 64'hC000_5000);

        $display("[TB] guard timing on SEL1");
        applyStimulus(1'b1, 3'd1, 32'h0000_00C3, 4'hF, 32'h0, lat);
        checkOutput("sel1_latency", lat, 64'd1);
        watchGuard(38'h300, 1, 32'h0, 32'h0000_00C3);

        $display("[TB] illegal nibble on SEL0");
        applyStimulus(1'b1, 3'd0, 32'h0000_000D, 4'hF, 32'h0, lat);
        for (int k = 0; k < G + 2; k++) begin
            checkOutput("illegal_no_force", {26'h0, force_oeb}, 64'h0);
            checkOutput("illegal_no_busy", {63'h0, busy}, 64'h0);
            @(negedge clk);
        end
        checkOutput("illegal_pin0", {32'h0, p0}, 64'h0);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'hF, 32'h2, lat);
        applyStimulus(1'b1, 3'd5, 32'h2, 4'h1, 32'h0, lat);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'hF, 32'h0, lat);

        $display("[TB] SEL2 write stalled behind SEL0 sequence");
        applyStimulus(1'b1, 3'd0, 32'h0000_0001, 4'hF, 32'h0, lat);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_0101, lat);
        applyStimulus(1'b1, 3'd2, 32'hC000_5001, 4'hF, 32'h0, lat);
        checkOutput("stall_latency", lat, 64'(G - 1));
        checkOutput("stall_pin0_applied", {32'h0, p0}, 64'h1);
        watchGuard(38'h1_0000, 2, 32'hC000_5000, 32'hC000_5001);

        $display("[TB] reset during guard");
        applyStimulus(1'b1, 3'd1, 32'h0, 4'hF, 32'h0, lat);
        @(negedge clk);
        checkOutput("pre_reset_busy", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_force_oeb", {26'h0, force_oeb}, 64'h0);
        checkOutput("abort_busy", {63'h0, busy}, 64'h0);
        checkOutput("abort_pins_lo", {p1, p0}, 64'h0);
        checkOutput("abort_pins_hi", {8'h0, p4, p3 | p2}, 64'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 3'd2, 32'h0, 4'hF, 32'h0, lat);
        applyStimulus(1'b0, 3'd4, 32'h0, 4'hF, 32'h0, lat);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'hF, 32'h0, lat);

`ifdef GPIO_SEL_LOCK_EN
        $display("[TB] lock register");
        applyStimulus(1'b1, 3'd6, 32'h1, 4'h1, 32'h0, lat);
        applyStimulus(1'b0, 3'd6, 32'h0, 4'hF, 32'h1, lat);
        applyStimulus(1'b1, 3'd0, 32'h1, 4'hF, 32'h0, lat);
        checkOutput("locked_latency", lat, 64'd1);
        repeat (G + 2) @(negedge clk);
        checkOutput("locked_pin0", {32'h0, p0}, 64'h0);
        checkOutput("locked_force", {26'h0, force_oeb}, 64'h0);
        applyStimulus(1'b0, 3'd0, 32'h0, 4'hF, 32'h0, lat);
        applyStimulus(1'b0, 3'd5, 32'h0, 4'hF, 32'h2, lat);
`endif

        checkOutput("scoreboard_drained", expQ.size(), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
